// File: rtl/open_risc_v_soc.sv
// Single-cycle RV32I SoC (no loads/stores): instruction ROM, core, register file.
// Define ECALL_HALT_EN to make ECALL freeze the core until reset; otherwise ECALL is a NOP.

module rom (
  input  logic [11:0] addr_i,
  output logic [31:0] data_o
);
  // Contents are loaded from outside by hierarchical writes.
  logic [31:0] rom_mem [0:4095];

  assign data_o = rom_mem[addr_i];
endmodule

module regfile (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);
  logic [31:0] regs [0:31];

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs[raddr2_i];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs[waddr_i] <= wdata_i;
    end
  end
endmodule

module open_risc_v (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o
);
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  logic [31:0] pc_q, pc_d;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_b, imm_j, imm_u;
  logic [31:0] rs1_val, rs2_val, op_b, alu_res, wb_data;
  logic        wb_en, taken, lt_s, lt_u;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'd0};
  assign pc_o   = pc_q;

  regfile regs_inst (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_val),
    .rdata2_o (rs2_val),
    .we_i     (wb_en),
    .waddr_i  (rd),
    .wdata_i  (wb_data)
  );

  assign op_b  = (opcode == OPC_OP) ? rs2_val : imm_i;
  assign shamt = op_b[4:0];
  assign lt_s  = $signed(rs1_val) < $signed(op_b);
  assign lt_u  = rs1_val < op_b;

  always_comb begin
    alu_res = 32'd0;
    case (funct3)
      3'b000: alu_res = (opcode == OPC_OP && instr_i[30]) ? rs1_val - op_b : rs1_val + op_b;
      3'b001: alu_res = rs1_val << shamt;
      3'b010: alu_res = {31'd0, lt_s};
      3'b011: alu_res = {31'd0, lt_u};
      3'b100: alu_res = rs1_val ^ op_b;
      3'b101: alu_res = instr_i[30] ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'b110: alu_res = rs1_val | op_b;
      default: alu_res = rs1_val & op_b;
    endcase
  end

  // Branch compares always use rs2, independent of op_b's immediate selection.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = rs1_val == rs2_val;
      3'b001:  taken = rs1_val != rs2_val;
      3'b100:  taken = $signed(rs1_val) <  $signed(rs2_val);
      3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  taken = rs1_val <  rs2_val;
      3'b111:  taken = rs1_val >= rs2_val;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_d    = pc_q + 32'd4;
    wb_en   = 1'b0;
    wb_data = 32'd0;
    case (opcode)
      OPC_OPIMM, OPC_OP: begin
        wb_en   = 1'b1;
        wb_data = alu_res;
      end
      OPC_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OPC_AUIPC: begin
        wb_en   = 1'b1;
        wb_data = pc_q + imm_u;
      end
      OPC_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_q + 32'd4;
        pc_d    = pc_q + imm_j;
      end
      OPC_JALR: begin
        wb_en   = 1'b1;
        wb_data = pc_q + 32'd4;
        pc_d    = (rs1_val + imm_i) & ~32'd1;
      end
      OPC_BRANCH: begin
        if (taken) pc_d = pc_q + imm_b;
      end
`ifdef ECALL_HALT_EN
      7'h73: begin
        if (instr_i == 32'h0000_0073) pc_d = pc_q;
      end
`else
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pc_q <= 32'd0;
    else          pc_q <= pc_d;
  end
endmodule

module open_risc_v_soc (
  input logic clk,
  input logic rst
);
  logic [31:0] pc;
  logic [31:0] instr;

  rom rom_inst (
    .addr_i (pc[13:2]),
    .data_o (instr)
  );

  open_risc_v open_risc_v_inst (
    .clk_i   (clk),
    .rst_n_i (rst),
    .instr_i (instr),
    .pc_o    (pc)
  );
endmodule

// File: tb/tb_open_risc_v_soc.sv
// Bench for open_risc_v_soc: directed ISA checks plus random programs run in
// lockstep against an instruction-level model of RV32I semantics.

module tb_open_risc_v_soc;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #10 clk = ~clk;

  open_risc_v_soc dut (.clk(clk), .rst(rst));

  typedef enum int {
    K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
    K_LUI, K_AUIPC, K_JAL, K_JALR,
    K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
    K_FENCE, K_CSR, K_LOAD, K_STORE, K_ECALL
  } kind_e;
  localparam int N_KIND = 34;

  typedef struct {
    kind_e kind;
    int    rd;
    int    rs1;
    int    rs2;
    int    imm;
  } ins_t;

  ins_t        prog[$];
  logic [31:0] m_x[32];
  logic [31:0] m_pc;
  bit          m_halt;
  int          m_rd;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(kind_e k, int rd, int rs1, int rs2, int imm);
    ins_t t;
    t.kind = k; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
    return t;
  endfunction

  function automatic logic [31:0] enc_i(logic [31:0] im, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {im[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(logic [31:0] im, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] encode(ins_t t);
    logic [31:0] im;
    logic [4:0]  rd, rs1, rs2;
    im = t.imm; rd = 5'(t.rd); rs1 = 5'(t.rs1); rs2 = 5'(t.rs2);
    case (t.kind)
      K_ADDI:  return enc_i(im, rs1, 3'd0, rd, 7'h13);
      K_SLTI:  return enc_i(im, rs1, 3'd2, rd, 7'h13);
      K_SLTIU: return enc_i(im, rs1, 3'd3, rd, 7'h13);
      K_XORI:  return enc_i(im, rs1, 3'd4, rd, 7'h13);
      K_ORI:   return enc_i(im, rs1, 3'd6, rd, 7'h13);
      K_ANDI:  return enc_i(im, rs1, 3'd7, rd, 7'h13);
      K_SLLI:  return enc_i(im, rs1, 3'd1, rd, 7'h13);
      K_SRLI:  return enc_i(im, rs1, 3'd5, rd, 7'h13);
      K_SRAI:  return enc_i(im | 32'h400, rs1, 3'd5, rd, 7'h13);
      K_ADD:   return enc_r(7'h00, rs2, rs1, 3'd0, rd);
      K_SUB:   return enc_r(7'h20, rs2, rs1, 3'd0, rd);
      K_SLL:   return enc_r(7'h00, rs2, rs1, 3'd1, rd);
      K_SLT:   return enc_r(7'h00, rs2, rs1, 3'd2, rd);
      K_SLTU:  return enc_r(7'h00, rs2, rs1, 3'd3, rd);
      K_XOR:   return enc_r(7'h00, rs2, rs1, 3'd4, rd);
      K_SRL:   return enc_r(7'h00, rs2, rs1, 3'd5, rd);
      K_SRA:   return enc_r(7'h20, rs2, rs1, 3'd5, rd);
      K_OR:    return enc_r(7'h00, rs2, rs1, 3'd6, rd);
      K_AND:   return enc_r(7'h00, rs2, rs1, 3'd7, rd);
      K_LUI:   return {im[19:0], rd, 7'h37};
      K_AUIPC: return {im[19:0], rd, 7'h17};
      K_JAL:   return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
      K_JALR:  return enc_i(im, rs1, 3'd0, rd, 7'h67);
      K_BEQ:   return enc_b(im, rs2, rs1, 3'd0);
      K_BNE:   return enc_b(im, rs2, rs1, 3'd1);
      K_BLT:   return enc_b(im, rs2, rs1, 3'd4);
      K_BGE:   return enc_b(im, rs2, rs1, 3'd5);
      K_BLTU:  return enc_b(im, rs2, rs1, 3'd6);
      K_BGEU:  return enc_b(im, rs2, rs1, 3'd7);
      K_FENCE: return 32'h0ff0_000f;
      K_CSR:   return {12'h300, rs1, 3'd2, rd, 7'h73};
      K_LOAD:  return {12'h000, rs1, 3'd2, rd, 7'h03};
      K_STORE: return {7'h00, rs2, rs1, 3'd2, 5'd0, 7'h23};
      default: return 32'h0000_0073;
    endcase
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    m_pc = 32'd0; m_halt = 1'b0; m_rd = 0;
  endfunction

  // One architectural step: instructions outside the program are NOPs (ROM is NOP-filled).
  function automatic void m_step();
    ins_t        t;
    int          idx;
    logic [31:0] a, b, iv, res, nxt;
    bit          wr;
    if (m_halt) return;
    idx = int'(m_pc[13:2]);
    t   = (idx < prog.size()) ? prog[idx] : mk(K_ADDI, 0, 0, 0, 0);
    a   = m_x[t.rs1]; b = m_x[t.rs2]; iv = t.imm;
    nxt = m_pc + 4; res = 0; wr = 1'b1;
    case (t.kind)
      K_ADDI:  res = a + iv;
      K_SLTI:  res = (int'(a) < t.imm) ? 1 : 0;
      K_SLTIU: res = (a < iv) ? 1 : 0;
      K_XORI:  res = a ^ iv;
      K_ORI:   res = a | iv;
      K_ANDI:  res = a & iv;
      K_SLLI:  res = a << t.imm;
      K_SRLI:  res = a >> t.imm;
      K_SRAI:  res = int'(a) >>> t.imm;
      K_ADD:   res = a + b;
      K_SUB:   res = a - b;
      K_SLL:   res = a << (b % 32);
      K_SLT:   res = (int'(a) < int'(b)) ? 1 : 0;
      K_SLTU:  res = (a < b) ? 1 : 0;
      K_XOR:   res = a ^ b;
      K_SRL:   res = a >> (b % 32);
      K_SRA:   res = int'(a) >>> (b % 32);
      K_OR:    res = a | b;
      K_AND:   res = a & b;
      K_LUI:   res = t.imm * 4096;
      K_AUIPC: res = m_pc + t.imm * 4096;
      K_JAL:   begin res = m_pc + 4; nxt = m_pc + iv; end
      K_JALR:  begin res = m_pc + 4; nxt = (a + iv) & ~32'd1; end
      K_BEQ:   begin wr = 0; if (a == b) nxt = m_pc + iv; end
      K_BNE:   begin wr = 0; if (a != b) nxt = m_pc + iv; end
      K_BLT:   begin wr = 0; if (int'(a) < int'(b)) nxt = m_pc + iv; end
      K_BGE:   begin wr = 0; if (int'(a) >= int'(b)) nxt = m_pc + iv; end
      K_BLTU:  begin wr = 0; if (a < b) nxt = m_pc + iv; end
      K_BGEU:  begin wr = 0; if (a >= b) nxt = m_pc + iv; end
      K_ECALL: begin
        wr = 0;
`ifdef ECALL_HALT_EN
        m_halt = 1'b1; nxt = m_pc;
`endif
      end
      default: wr = 0;
    endcase
    m_rd = t.rd;
    if (wr && t.rd != 0) m_x[t.rd] = res;
    m_pc = nxt;
  endfunction

  function automatic logic [31:0] dut_reg(int i);
    return dut.open_risc_v_inst.regs_inst.regs[i];
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[i] = 32'h0000_0013;
    for (int i = 0; i < prog.size(); i++) dut.rom_inst.rom_mem[i] = encode(prog[i]);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst = 1'b0;
    #29;
    if (check) begin
      check_val("reset pc", dut.open_risc_v_inst.pc_q, 32'd0);
      for (int i = 0; i < 32; i++) check_val($sformatf("reset x%0d", i), dut_reg(i), 32'd0);
    end
    #1;
    @(negedge clk);
    rst = 1'b1;
    m_reset();
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic run_lockstep(input int ncyc, input int pnum);
    for (int c = 0; c < ncyc; c++) begin
      edge_();
      m_step();
      check_val($sformatf("p%0d c%0d pc", pnum, c), dut.open_risc_v_inst.pc_q, m_pc);
      check_val($sformatf("p%0d c%0d x%0d", pnum, c, m_rd), dut_reg(m_rd), m_x[m_rd]);
    end
    for (int i = 0; i < 32; i++) check_val($sformatf("p%0d end x%0d", pnum, i), dut_reg(i), m_x[i]);
  endtask

  function automatic int rnd_off();
    int o;
    o = int'($urandom_range(1, 12)) * 4;
    return ($urandom_range(0, 1) == 1) ? -o : o;
  endfunction

  task automatic gen_prog(input int len);
    ins_t t;
    prog.delete();
    for (int i = 0; i < len; i++) begin
      t.kind = kind_e'($urandom_range(0, N_KIND - 1));
      t.rd   = int'($urandom_range(0, 15));
      t.rs1  = int'($urandom_range(0, 15));
      t.rs2  = int'($urandom_range(0, 15));
      t.imm  = int'($urandom_range(0, 4095)) - 2048;
      case (t.kind)
        K_SLLI, K_SRLI, K_SRAI: t.imm = int'($urandom_range(0, 31));
        K_LUI, K_AUIPC:         t.imm = int'($urandom_range(0, 20'hfffff));
        K_JAL, K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU: t.imm = rnd_off();
        K_JALR: begin t.rs1 = 0; t.imm = int'($urandom_range(0, len - 1)) * 4 + 1; end
        default: ;
      endcase
      prog.push_back(t);
    end
  endtask

  initial begin
    // ALU basics, reset behaviour and mid-program abort
    prog = '{mk(K_ADDI, 1, 0, 0, 5), mk(K_ANDI, 2, 1, 0, 3), mk(K_ADDI, 3, 0, 0, -1)};
    load_prog();
    do_reset(1'b1);
    edge_();
    check_val("rom0 x1 after 1 edge", dut_reg(1), 32'd5);
    edge_();
    check_val("andi x1", dut_reg(1), 32'd5);
    check_val("andi x2", dut_reg(2), 32'd1);
    edge_();
    check_val("addi -1 x3", dut_reg(3), 32'hffff_ffff);
    @(posedge clk);
    #5;
    rst = 1'b0;
    #1;
    check_val("abort pc", dut.open_risc_v_inst.pc_q, 32'd0);
    check_val("abort x1", dut_reg(1), 32'd0);
    check_val("abort x3", dut_reg(3), 32'd0);
    #20;
    @(negedge clk);
    rst = 1'b1;
    edge_();
    check_val("restart x1", dut_reg(1), 32'd5);
    check_val("restart x2", dut_reg(2), 32'd0);

    prog = '{mk(K_LUI, 4, 0, 0, 32'h12345), mk(K_AUIPC, 5, 0, 0, 1)};
    load_prog();
    do_reset(1'b0);
    edge_();
    edge_();
    check_val("lui x4", dut_reg(4), 32'h1234_5000);
    check_val("auipc x5", dut_reg(5), 32'h0000_1004);

    prog = '{mk(K_BEQ, 0, 0, 0, 8), mk(K_ADDI, 6, 0, 0, 1), mk(K_JAL, 1, 0, 0, 12),
             mk(K_ADDI, 7, 0, 0, 1), mk(K_ADDI, 7, 0, 0, 2), mk(K_BNE, 0, 0, 0, 8),
             mk(K_ADDI, 0, 0, 0, 7), mk(K_ADDI, 8, 0, 0, 3)};
    load_prog();
    do_reset(1'b0);
    edge_();
    check_val("beq taken pc", dut.open_risc_v_inst.pc_q, 32'd8);
    edge_();
    check_val("jal pc", dut.open_risc_v_inst.pc_q, 32'd20);
    check_val("jal x1", dut_reg(1), 32'd12);
    check_val("skipped x6", dut_reg(6), 32'd0);
    edge_();
    check_val("bne fallthrough pc", dut.open_risc_v_inst.pc_q, 32'd24);
    edge_();
    check_val("x0 stays 0", dut_reg(0), 32'd0);
    edge_();
    check_val("after x8", dut_reg(8), 32'd3);
    check_val("skipped x7", dut_reg(7), 32'd0);

    prog = '{mk(K_ADDI, 9, 0, 0, 40), mk(K_JALR, 9, 9, 0, 1)};
    load_prog();
    do_reset(1'b0);
    edge_();
    edge_();
    check_val("jalr pc bit0 cleared", dut.open_risc_v_inst.pc_q, 32'd40);
    check_val("jalr rd=rs1 link", dut_reg(9), 32'd8);

    for (int p = 0; p < 20; p++) begin
      gen_prog(48);
      load_prog();
      do_reset(1'b0);
      run_lockstep(120, p);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
